// File: rtl/vedic_seq_mul.sv
// Sequential Vedic multiplier: one WIDTH/2 x WIDTH/2 multiplier time-shared over four cross products.
// Optional two's-complement mode is built in when VEDIC_SIGNED_EN is defined (adds port signed_i).
module vedic_seq_mul #(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef VEDIC_SIGNED_EN
    input  logic                 signed_i,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   m_o
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_m;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [HALF-1:0]      w_mul_a;
    logic [HALF-1:0]      w_mul_b;
    logic [WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]   w_term;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_MUL0;
                end
            end
            S_MUL0: w_state_next = S_MUL1;
            S_MUL1: w_state_next = S_MUL2;
            S_MUL2: w_state_next = S_MUL3;
            S_MUL3: w_state_next = S_DONE;
            S_DONE: begin
                // A new operand pair can be taken on the same edge the result leaves.
                if (out_ready) begin
                    in_ready     = 1'b1;
                    w_state_next = in_valid ? S_MUL0 : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);
    assign m_o       = r_m;

`ifdef VEDIC_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg;

    assign w_a_neg  = signed_i & a_i[WIDTH-1];
    assign w_b_neg  = signed_i & b_i[WIDTH-1];
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_a_mag  = w_a_neg ? (~a_i + WIDTH'(1)) : a_i;
    assign w_b_mag  = w_b_neg ? (~b_i + WIDTH'(1)) : b_i;
    assign w_result = r_neg ? (~w_sum + (2*WIDTH)'(1)) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_a_neg ^ w_b_neg;
        end
    end
`else
    assign w_a_mag  = a_i;
    assign w_b_mag  = b_i;
    assign w_result = w_sum;
`endif

    always_comb begin
        w_mul_a = r_a[HALF-1:0];
        w_mul_b = r_b[HALF-1:0];
        w_term  = '0;
        case (r_state)
            S_MUL1: w_mul_b = r_b[WIDTH-1:HALF];
            S_MUL2: w_mul_a = r_a[WIDTH-1:HALF];
            S_MUL3: begin
                w_mul_a = r_a[WIDTH-1:HALF];
                w_mul_b = r_b[WIDTH-1:HALF];
            end
            default: ;
        endcase
        case (r_state)
            S_MUL0:         w_term = {{WIDTH{1'b0}}, w_prod};
            S_MUL1, S_MUL2: w_term = {{HALF{1'b0}}, w_prod, {HALF{1'b0}}};
            S_MUL3:         w_term = {w_prod, {WIDTH{1'b0}}};
            default:        w_term = '0;
        endcase
    end

    assign w_prod = WIDTH'(w_mul_a) * WIDTH'(w_mul_b);
    assign w_sum  = r_acc + w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_m   <= '0;
        end else if (w_accept) begin
            r_a   <= w_a_mag;
            r_b   <= w_b_mag;
            r_acc <= '0;
        end else begin
            case (r_state)
                S_MUL0, S_MUL1, S_MUL2: r_acc <= w_sum;
                S_MUL3: begin
                    r_acc <= w_sum;
                    r_m   <= w_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Self-checking bench for vedic_seq_mul: constant vector table, corner sequences and random
// back-to-back traffic against a plain-arithmetic product model.
module tb_vedic_seq_mul;

    localparam int W = 128;
    localparam int P = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          in_ready;
    logic          out_valid;
    logic [P-1:0]  m_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef VEDIC_SIGNED_EN
    logic          sig_main = 1'b0;
    logic          s_signed = 1'b0;
    logic          s_in_valid = 1'b0;
    logic          s_out_ready = 1'b0;
    logic [7:0]    s_a = '0;
    logic [7:0]    s_b = '0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [15:0]   s_m;

    vedic_seq_mul #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .signed_i(sig_main),
        .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
        .out_valid(out_valid), .out_ready(out_ready), .m_o(m_o)
    );

    vedic_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .signed_i(s_signed),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a_i(s_a), .b_i(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .m_o(s_m)
    );
`else
    vedic_seq_mul #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
        .out_valid(out_valid), .out_ready(out_ready), .m_o(m_o)
    );
`endif

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [P-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [P-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return P'(a) * P'(b);
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with latency measurement; junk operands are presented while busy.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [P-1:0] exp);
        int lat;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        check({name, " ready"}, P'(in_ready), P'(1));
        in_valid = 1'b1;
        a_i = a;
        b_i = b;
        tick();
        a_i = rand_w();
        b_i = rand_w();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        check({name, " latency"}, P'(lat), P'(4));
        check({name, " product"}, m_o, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef VEDIC_SIGNED_EN
    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [15:0] exp);
        int lat;
        s_in_valid = 1'b1;
        s_signed = sgn;
        s_a = a;
        s_b = b;
        tick();
        s_in_valid = 1'b0;
        s_signed = ~sgn;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (s_out_valid) begin
                lat = i;
                break;
            end
        end
        check({name, " latency"}, P'(lat), P'(4));
        check(name, P'(s_m), P'(exp));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
    endtask
`endif

    vec_t vecs[6];

    initial begin
        logic [P-1:0] q[$];
        logic [P-1:0] held_m;
        logic [P-1:0] exp_bp;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        int bad_m, bad_v, bad_r, cyc, produced, accepted, last_out, stray;
        bit acc_now;

        vecs[0] = '{"max*max", {W{1'b1}}, {W{1'b1}},
                    {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1}};
        vecs[1] = '{"split*3", 128'h1_0000_0000_0000_0001, 128'h3,
                    256'h3_0000_0000_0000_0003};
        vecs[2] = '{"carry sq", 128'h1_8000_0000_0000_0000, 128'h1_8000_0000_0000_0000,
                    256'h2_4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[3] = '{"zero", 128'h0, {W{1'b1}}, 256'h0};
        vecs[4] = '{"one*max", 128'h1, {W{1'b1}}, {128'h0, {W{1'b1}}}};
        vecs[5] = '{"hi*hi", 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000,
                    128'h2_0000_0000_0000_0000,
                    256'h1_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000_0000_0000_0000_0000};

        // Reset state
        repeat (3) tick();
        check("reset out_valid", P'(out_valid), P'(0));
        check("reset m_o", m_o, '0);
        check("reset in_ready", P'(in_ready), P'(1));
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure: result held for 10 cycles, then released with a new op on the same edge
        in_valid = 1'b1;
        a_i = 128'hDEAD_BEEF;
        b_i = 128'h1234_5678_9ABC;
        exp_bp = ref_mul(a_i, b_i);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp first valid", P'(out_valid), P'(1));
        held_m = m_o;
        check("bp first product", held_m, exp_bp);
        bad_m = 0; bad_v = 0; bad_r = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_i = rand_w();
            b_i = rand_w();
            #1;
            if (m_o !== held_m) bad_m++;
            if (out_valid !== 1'b1) bad_v++;
            if (in_ready !== 1'b0) bad_r++;
            tick();
        end
        check("bp m_o stable", P'(bad_m), P'(0));
        check("bp out_valid stable", P'(bad_v), P'(0));
        check("bp in_ready low", P'(bad_r), P'(0));
        na = rand_w();
        nb = rand_w();
        a_i = na;
        b_i = nb;
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", P'(in_ready), P'(1));
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp accepted (busy)", P'(out_valid), P'(0));
        repeat (4) tick();
        check("bp second valid", P'(out_valid), P'(1));
        check("bp second product", m_o, ref_mul(na, nb));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back random stream
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_i = rand_w();
        b_i = rand_w();
        cyc = 0; produced = 0; accepted = 0; last_out = -1;
        while (produced < 20 && cyc < 400) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b unexpected output", m_o, ~m_o);
                end else begin
                    check($sformatf("b2b product %0d", produced), m_o, q.pop_front());
                end
                if (last_out >= 0) check("b2b spacing", P'(cyc - last_out), P'(5));
                last_out = cyc;
                produced++;
            end
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                q.push_back(ref_mul(a_i, b_i));
                accepted++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                a_i = (accepted % 4 == 0) ? {W{1'b1}} : rand_w();
                b_i = rand_w();
                if (accepted == 20) in_valid = 1'b0;
            end
        end
        check("b2b produced all", P'(produced), P'(20));
        tick();
        out_ready = 1'b0;

        // Reset while in MUL2
        held_m = m_o;
        in_valid = 1'b1;
        a_i = rand_w();
        b_i = rand_w();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", P'(out_valid), P'(0));
        check("midreset m_o", m_o, '0);
        check("midreset had prior result", P'(held_m != '0), P'(1));
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) stray++;
        end
        check("midreset op discarded", P'(stray), P'(0));
        na = rand_w();
        nb = rand_w();
        run_op("after reset", na, nb, ref_mul(na, nb));

`ifdef VEDIC_SIGNED_EN
        run8("s -128*-128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("s -1*1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
        run8("u FF*FF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic sg;
            int sa, sb, pr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            sg = 1'($urandom);
            sa = sg ? int'($signed(ra)) : int'(ra);
            sb = sg ? int'($signed(rb)) : int'(rb);
            pr = sa * sb;
            run8($sformatf("rand8 %0d", i), ra, rb, sg, pr[15:0]);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
